// File: rtl/arb_pkg.sv
// Shared constants, FSM state encoding and the round-robin search helper
// for the 8-way decoded-resource arbiter.
package arb_pkg;

    localparam int unsigned N     = 8;
    localparam int unsigned IDX_W = 3;

    typedef enum logic {
        StIdle  = 1'b0,
        StGrant = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } win_t;

    // First set request at or after start, wrapping modulo N. Scanning from the
    // far end lets the nearest hit overwrite, so no early exit is needed.
    function automatic win_t next_winner(input logic [N-1:0] req, input logic [IDX_W-1:0] start);
        win_t             w;
        logic [IDX_W-1:0] k;
        w = '0;
        for (int i = N - 1; i >= 0; i--) begin
            k = start + IDX_W'(i);
            if (req[k]) begin
                w.found = 1'b1;
                w.idx   = k;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/gnt_decoder.sv
// Combinational 3-to-8 decoder with enable; all outputs low when disabled.
module gnt_decoder
    import arb_pkg::*;
(
    input  logic [IDX_W-1:0] idx,
    input  logic             en,
    output logic [N-1:0]     onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_decoder_arbiter.sv
// Round-robin arbiter over 8 requesters with a hold limit; drives a registered
// grant index/enable and the decoded one-hot select.
module rr_decoder_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_en,
    output logic [N-1:0]     gnt,
    output logic             busy
);

    localparam int unsigned HoldMax = (MAX_HOLD == 0) ? 1 : MAX_HOLD;
    localparam int unsigned CntW    = $clog2(HoldMax + 1);

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             en_q, en_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [CntW-1:0]  cnt_q, cnt_d;

    win_t win_ptr;
    win_t win_idx;
    logic others;

    assign win_ptr = next_winner(req, ptr_q + IDX_W'(1));
    assign win_idx = next_winner(req, idx_q + IDX_W'(1));
    // In StGrant gnt is the holder's one-hot, so this masks out the holder.
    assign others  = |(req & ~gnt);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        en_d    = en_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (win_ptr.found) begin
                    state_d = StGrant;
                    idx_d   = win_ptr.idx;
                    en_d    = 1'b1;
                    ptr_d   = win_ptr.idx;
                    cnt_d   = CntW'(1);
                end
            end
            StGrant: begin
                if (!req[idx_q]) begin
                    if (others) begin
                        idx_d = win_idx.idx;
                        ptr_d = win_idx.idx;
                        cnt_d = CntW'(1);
                    end else begin
                        state_d = StIdle;
                        en_d    = 1'b0;
                    end
                end else if (MAX_HOLD != 0 && cnt_q == CntW'(MAX_HOLD) && others) begin
                    idx_d = win_idx.idx;
                    ptr_d = win_idx.idx;
                    cnt_d = CntW'(1);
                end else if (cnt_q < CntW'(MAX_HOLD)) begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: begin
                state_d = StIdle;
                en_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            idx_q   <= '0;
            en_q    <= 1'b0;
            ptr_q   <= IDX_W'(N - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            en_q    <= en_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    gnt_decoder u_gnt_decoder (
        .idx    (idx_q),
        .en     (en_q),
        .onehot (gnt)
    );

    assign gnt_idx = idx_q;
    assign gnt_en  = en_q;
    assign busy    = (state_q == StGrant);

endmodule

// File: tb/tb_rr_decoder_arbiter.sv
// Bench for rr_decoder_arbiter: two instances (hold limit 4 and unlimited) share
// stimulus and are compared every cycle against a behavioural grant model.
module tb_rr_decoder_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] req = 8'h00;

    logic [2:0] a_idx, b_idx;
    logic       a_en, b_en, a_busy, b_busy;
    logic [7:0] a_gnt, b_gnt;

    int n_checks = 0;
    int n_err    = 0;
    bit cmp_on   = 1'b0;

    // Model state per instance: 0 -> hold limit 4, 1 -> unlimited.
    int mh[2];
    bit m_act[2];
    int m_idx[2];
    int m_ptr[2];
    int m_held[2];

    always #5 clk = ~clk;

    rr_decoder_arbiter #(.MAX_HOLD(4)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .req(req),
        .gnt_idx(a_idx), .gnt_en(a_en), .gnt(a_gnt), .busy(a_busy)
    );

    rr_decoder_arbiter #(.MAX_HOLD(0)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .req(req),
        .gnt_idx(b_idx), .gnt_en(b_en), .gnt(b_gnt), .busy(b_busy)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int winner(input logic [7:0] r, input int start);
        for (int off = 0; off < 8; off++) begin
            if (r[(start + off) % 8]) return (start + off) % 8;
        end
        return -1;
    endfunction

    task automatic give(input int m, input int w);
        m_act[m]  = 1'b1;
        m_idx[m]  = w;
        m_ptr[m]  = w;
        m_held[m] = 1;
    endtask

    task automatic model_step(input int m, input logic [7:0] r, input logic rs);
        logic [7:0] rest;
        if (!rs) begin
            m_act[m] = 1'b0; m_idx[m] = 0; m_ptr[m] = 7; m_held[m] = 0;
        end else if (!m_act[m]) begin
            if (r != 8'h00) give(m, winner(r, (m_ptr[m] + 1) % 8));
        end else begin
            rest = r;
            rest[m_idx[m]] = 1'b0;
            if (!r[m_idx[m]]) begin
                if (rest != 8'h00) give(m, winner(r, (m_idx[m] + 1) % 8));
                else m_act[m] = 1'b0;
            end else if (mh[m] != 0 && m_held[m] >= mh[m] && rest != 8'h00) begin
                give(m, winner(r, (m_idx[m] + 1) % 8));
            end else begin
                m_held[m]++;
            end
        end
    endtask

    task automatic cmp_dut(input string tag, input int m, input logic [2:0] gi, input logic ge,
                           input logic [7:0] g, input logic b);
        logic [7:0] eg;
        eg = 8'h00;
        if (m_act[m]) eg[m_idx[m]] = 1'b1;
        chk({tag, "_idx"},  32'(gi), 32'(m_idx[m]));
        chk({tag, "_en"},   32'(ge), 32'(m_act[m]));
        chk({tag, "_gnt"},  32'(g),  32'(eg));
        chk({tag, "_busy"}, 32'(b),  32'(m_act[m]));
    endtask

    always @(negedge clk) begin
        if (cmp_on) begin
            cmp_dut("a", 0, a_idx, a_en, a_gnt, a_busy);
            cmp_dut("b", 1, b_idx, b_en, b_gnt, b_busy);
        end
    end

    task automatic step(input logic [7:0] r, input logic rs);
        req   = r;
        rst_n = rs;
        @(posedge clk);
        model_step(0, r, rs);
        model_step(1, r, rs);
        #1;
    endtask

    initial begin
        mh[0] = 4;
        mh[1] = 0;
        for (int m = 0; m < 2; m++) begin
            m_act[m] = 1'b0; m_idx[m] = 0; m_ptr[m] = 7; m_held[m] = 0;
        end

        // 1: reset values, idle, then reset mid-grant restarts the pointer
        step(8'h00, 1'b0);
        step(8'h00, 1'b0);
        cmp_on = 1'b1;
        chk("rst_gnt", 32'(a_gnt), 32'h00);
        chk("rst_en", 32'(a_en), 32'h0);
        chk("rst_idx", 32'(a_idx), 32'h0);
        for (int k = 0; k < 5; k++) begin
            step(8'h00, 1'b1);
            chk("idle_gnt", 32'(a_gnt), 32'h00);
            chk("idle_busy", 32'(a_busy), 32'h0);
        end
        step(8'h10, 1'b1);
        chk("t1_first", 32'(a_gnt), 32'h10);
        step(8'h10, 1'b1);
        step(8'h10, 1'b0);
        chk("t1_midrst_gnt", 32'(a_gnt), 32'h00);
        step(8'h81, 1'b1);
        chk("t1_ptr_restart", 32'(a_idx), 32'h0);
        chk("t1_ptr_restart_en", 32'(a_en), 32'h1);

        // 2: single requester held for 3 cycles
        step(8'h00, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step(8'h01, 1'b1);
            chk("t2_gnt", 32'(a_gnt), 32'h01);
        end
        step(8'h00, 1'b1);
        chk("t2_rel_gnt", 32'(a_gnt), 32'h00);
        chk("t2_rel_busy", 32'(a_busy), 32'h0);

        // 3: all requesting: 4-cycle slots rotate with no gap; unlimited holds 0
        step(8'h00, 1'b0);
        for (int k = 0; k < 36; k++) begin
            step(8'hFF, 1'b1);
            chk("t3_rot_idx", 32'(a_idx), 32'((k / 4) % 8));
            chk("t3_rot_en", 32'(a_en), 32'h1);
            chk("t3_unlim_idx", 32'(b_idx), 32'h0);
        end

        // 4: back-to-back release from index 5
        step(8'h00, 1'b0);
        step(8'h20, 1'b1);
        chk("t4_idx5", 32'(a_idx), 32'h5);
        step(8'h06, 1'b1);
        chk("t4_gnt", 32'(a_gnt), 32'h02);
        chk("t4_en", 32'(a_en), 32'h1);
        chk("t4_model", 32'(m_idx[0]), 32'h1);

        // 5: wrap-around from ptr=6
        step(8'h00, 1'b0);
        step(8'h40, 1'b1);
        step(8'h00, 1'b1);
        chk("t5_idle_idx", 32'(a_idx), 32'h6);
        step(8'h41, 1'b1);
        chk("t5_wrap", 32'(a_idx), 32'h0);
        step(8'h40, 1'b1);
        chk("t5_after", 32'(a_idx), 32'h6);
        chk("t5_after_gnt", 32'(a_gnt), 32'h40);

        // 6: unlimited hold, then drop req[0]
        step(8'h00, 1'b0);
        for (int k = 0; k < 20; k++) begin
            step(8'h09, 1'b1);
            chk("t6_hold", 32'(b_gnt), 32'h01);
        end
        step(8'h08, 1'b1);
        chk("t6_next", 32'(b_idx), 32'h3);
        chk("t6_next_gnt", 32'(b_gnt), 32'h08);

        // Randomized traffic with sparse patterns and occasional reset
        for (int k = 0; k < 600; k++) begin
            logic [7:0] r;
            logic       rs;
            r = 8'($urandom);
            if ($urandom_range(0, 3) == 0) r = r & 8'($urandom);
            if ($urandom_range(0, 7) == 0) r = 8'h00;
            rs = ($urandom_range(0, 49) != 0);
            step(r, rs);
        end

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/rr_decoder_arbiter.md
Name: rr_decoder_arbiter

Overview:
Round-robin arbiter that shares one 8-way decoded resource among 8 requesters. It selects one winner, then drives a 3-bit index, an enable and the matching one-hot select line. It sits between the request sources and the 3-to-8 decode stage, and adds a fairness limit so that no requester can hold the resource indefinitely.

Parameters:
N, 8, number of requesters; fixed at 8 for this block.
IDX_W, 3, width of the grant index; must equal log2(N).
MAX_HOLD, 4, maximum grant cycles before preemption when another requester is pending; 0 means unlimited (no preemption).

Ports:
clk  in  1  rising-edge clock.
rst_n  in  1  synchronous reset, active-low.
req  in  8  request vector; req[i]=1 means requester i wants the resource.
gnt_idx  out  3  index of the current grant holder.
gnt_en  out  1  grant valid; drives the decode-stage enable.
gnt  out  8  one-hot grant, equal to decode(gnt_idx, gnt_en); all zeros when gnt_en=0.
busy  out  1  high while in state GRANT.

Behaviour:
- One clock domain. Reset is synchronous and active-low: it acts on the next rising clk edge with rst_n=0.
- Reset values:
  - gnt_idx=0, gnt_en=0, gnt=8'h00, busy=0.
  - State=IDLE, rr pointer ptr=7, so the first search starts at index 0.
  - hold_cnt=0.
- All outputs are registered. A grant appears 1 cycle after the request is sampled.
- Winner search: the first i with req[i]=1, scanning ptr+1, ptr+2, ..., wrapping modulo 8. ptr itself is searched last.
- State IDLE:
  - req==0: stay; outputs stay at idle values.
  - req!=0: go to GRANT. gnt_idx=winner, gnt_en=1, ptr=winner, hold_cnt=1.
- State GRANT, evaluated every cycle with idx=gnt_idx:
  - Release (req[idx]=0):
    - If any other req is set, grant the next winner back-to-back, with no idle cycle. Search from idx+1; ptr=new idx; hold_cnt=1.
    - Otherwise go to IDLE with gnt_en=0. gnt_idx keeps its last value.
  - Preempt (req[idx]=1, MAX_HOLD!=0, hold_cnt==MAX_HOLD, and any other req set): grant the next winner from idx+1; hold_cnt=1.
  - Hold (req[idx]=1, no preemption): keep the grant. hold_cnt increments and saturates at MAX_HOLD, so that a later arrival preempts on the next cycle.
- Simultaneous release plus new requests: handled like a release; rotation starts at idx+1.
- A requester that drops and re-raises in the same cycle is not observable. A continuously high req[idx] counts as a hold.
- Only one gnt bit is ever set. gnt_en=0 implies gnt=0.
- Reset mid-grant: the next edge with rst_n=0 forces the reset values regardless of state or req.
- req is assumed synchronous to clk; no internal synchronizers.

Decomposition:
- Package arb_pkg:
  - N and IDX_W constants.
  - State encoding IDLE=1'b0, GRANT=1'b1.
  - A function next_winner(req, start) that returns the index and a found flag.
- One sub-module, gnt_decoder: combinational 3-to-8 decoder with enable (inputs idx[2:0], en; output onehot[7:0]). It is instantiated on the registered gnt_idx/gnt_en to produce gnt.
- Everything else (pointer, counter, FSM) lives in rr_decoder_arbiter.

Test Plan:
1. Reset, then req=8'h00 for 5 cycles -> gnt_en=0, gnt=8'h00, busy=0 throughout. Then assert rst_n=0 during a grant -> next edge gives gnt=8'h00, ptr restarts, so the next req=8'h81 grants index 0.
2. req=8'h01 held for 3 cycles, then 8'h00 -> gnt=8'h01 from cycle 1 for 3 cycles, then gnt=8'h00, busy=0.
3. Fairness with req=8'hFF held constant and MAX_HOLD=4 -> grants rotate 0,1,2,...,7,0, each held exactly 4 cycles, with no gap cycles.
4. Back-to-back release: grant at index 5, then req changes from 8'h20 to 8'h06 -> the next cycle grants index 1 (search 6,7,0,1), gnt=8'h02, with no idle cycle.
5. Wrap-around: ptr=6, req=8'h41 -> grant index 0 (7 is searched before 0, then 0); after release with req=8'h40, grant index 6.
6. MAX_HOLD=0, req=8'h09 constant -> index 0 is held indefinitely (run 20 cycles). Dropping req[0] then grants index 3 on the next cycle.
